// File: rtl/fp16_to_int_seq.sv
// Iterative FP16 -> signed integer converter, truncating toward zero, one alignment bit per cycle.
// Latency: resp_valid rises cnt+3 edges after accept, counting the accept edge as the first (3..13).
// Backpressure: one conversion in flight; req_ready low until the DONE handshake; result held while resp_ready low.
module fp16_to_int_seq #(
    parameter int OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [15:0]          req_data,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [OUT_WIDTH-1:0] resp_data,
    output logic                 resp_inexact,
    output logic                 resp_overflow,
    output logic                 resp_invalid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_FINISH,
        S_DONE
    } state_t;

    // Magnitude limits are held 33 bits wide so that OUT_WIDTH=32 still fits.
    localparam logic [32:0]          NEG_LIM = 33'd1 << (OUT_WIDTH - 1);
    localparam logic [32:0]          POS_LIM = NEG_LIM - 33'd1;
    localparam logic [OUT_WIDTH-1:0] SAT_POS = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] SAT_NEG = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    state_t state;
    state_t state_nxt;

    logic        sign_q;
    logic [25:0] mag_q;
    logic [3:0]  cnt_q;
    logic        left_q;
    logic        sticky_q;
    logic        nan_q;
    logic        inf_q;

    logic        accept;
    logic [4:0]  req_exp;
    logic [9:0]  req_frac;
    logic [4:0]  unb_exp;

    logic [32:0]          mag_ext;
    logic [OUT_WIDTH-1:0] mag_ow;
    logic                 range_ovf;
    logic [OUT_WIDTH-1:0] fin_data;
    logic                 fin_inexact;
    logic                 fin_overflow;
    logic                 fin_invalid;

    assign accept   = req_valid && req_ready;
    assign req_exp  = req_data[14:10];
    assign req_frac = req_data[9:0];
    assign unb_exp  = req_exp - 5'd15;

    // State register; reset aborts any conversion in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state: SHIFT runs until the alignment count is exhausted.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (req_valid)       state_nxt = S_SHIFT;
            S_SHIFT:  if (cnt_q == 4'd0)   state_nxt = S_FINISH;
            S_FINISH:                      state_nxt = S_DONE;
            S_DONE:   if (resp_ready)      state_nxt = S_IDLE;
            default:                       state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs are pure decodes of the state.
    always_comb begin
        req_ready  = (state == S_IDLE);
        resp_valid = (state == S_DONE);
    end

    // Final range check, saturation and two's-complement negation.
    always_comb begin
        mag_ext      = 33'(mag_q);
        mag_ow       = OUT_WIDTH'(mag_q);
        range_ovf    = sign_q ? (mag_ext > NEG_LIM) : (mag_ext > POS_LIM);
        fin_data     = '0;
        fin_inexact  = 1'b0;
        fin_overflow = 1'b0;
        fin_invalid  = 1'b0;
        if (nan_q) begin
            fin_invalid = 1'b1;
        end else if (inf_q || range_ovf) begin
            fin_overflow = 1'b1;
            fin_data     = sign_q ? SAT_NEG : SAT_POS;
        end else begin
            fin_data    = sign_q ? (-mag_ow) : mag_ow;
            fin_inexact = sticky_q;
        end
    end

    // Datapath: classify on accept, align one bit per SHIFT cycle, latch result in FINISH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_q        <= 1'b0;
            mag_q         <= '0;
            cnt_q         <= '0;
            left_q        <= 1'b0;
            sticky_q      <= 1'b0;
            nan_q         <= 1'b0;
            inf_q         <= 1'b0;
            resp_data     <= '0;
            resp_inexact  <= 1'b0;
            resp_overflow <= 1'b0;
            resp_invalid  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        sign_q   <= req_data[15];
                        mag_q    <= '0;
                        cnt_q    <= '0;
                        left_q   <= 1'b0;
                        sticky_q <= 1'b0;
                        nan_q    <= 1'b0;
                        inf_q    <= 1'b0;
                        if (req_exp == 5'd31) begin
                            nan_q <= (req_frac != 10'd0);
                            inf_q <= (req_frac == 10'd0);
                        end else if (req_exp < 5'd15) begin
                            // Below 1.0 everything truncates away; any nonzero bit is inexact.
                            sticky_q <= (req_exp != 5'd0) || (req_frac != 10'd0);
                        end else begin
                            mag_q <= {15'd0, 1'b1, req_frac};
                            if (unb_exp >= 5'd10) begin
                                left_q <= 1'b1;
                                cnt_q  <= 4'(unb_exp - 5'd10);
                            end else begin
                                left_q <= 1'b0;
                                cnt_q  <= 4'(5'd10 - unb_exp);
                            end
                        end
                    end
                end
                S_SHIFT: begin
                    if (cnt_q != 4'd0) begin
                        if (left_q) begin
                            mag_q <= {mag_q[24:0], 1'b0};
                        end else begin
                            mag_q    <= {1'b0, mag_q[25:1]};
                            sticky_q <= sticky_q | mag_q[0];
                        end
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_FINISH: begin
                    resp_data     <= fin_data;
                    resp_inexact  <= fin_inexact;
                    resp_overflow <= fin_overflow;
                    resp_invalid  <= fin_invalid;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp16_to_int_seq.sv
// Directed bench for fp16_to_int_seq: 32- and 16-bit instances run the same vectors in lockstep.
// Latency is counted in edges with the accept edge as edge 1.
// Covers reset, normals, truncation, specials, 16-bit saturation, backpressure and mid-conversion reset.
module tb_fp16_to_int_seq;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [15:0] req_data;
    logic        resp_ready;

    logic        req_ready32;
    logic        resp_valid32;
    logic [31:0] resp_data32;
    logic        inexact32;
    logic        overflow32;
    logic        invalid32;

    logic        req_ready16;
    logic        resp_valid16;
    logic [15:0] resp_data16;
    logic        inexact16;
    logic        overflow16;
    logic        invalid16;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [15:0] op;
        logic [31:0] r32;
        logic [2:0]  f32;   // {inexact, overflow, invalid}
        logic [15:0] r16;
        logic [2:0]  f16;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    fp16_to_int_seq #(.OUT_WIDTH(32)) dut32 (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready32),
        .req_data      (req_data),
        .resp_valid    (resp_valid32),
        .resp_ready    (resp_ready),
        .resp_data     (resp_data32),
        .resp_inexact  (inexact32),
        .resp_overflow (overflow32),
        .resp_invalid  (invalid32)
    );

    fp16_to_int_seq #(.OUT_WIDTH(16)) dut16 (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready16),
        .req_data      (req_data),
        .resp_valid    (resp_valid16),
        .resp_ready    (resp_ready),
        .resp_data     (resp_data16),
        .resp_inexact  (inexact16),
        .resp_overflow (overflow16),
        .resp_invalid  (invalid16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Accepts op on the next edge, returns the edge count until resp_valid (accept edge = 1).
    task automatic issue_and_wait(input logic [15:0] op, output int lat);
        @(negedge clk);
        req_data  = op;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid32 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_vec(input int i);
        int    lat;
        string tg;
        tg = $sformatf("v%0d_%04h", i, vecs[i].op);
        @(negedge clk);
        check_eq({tg, "_req_ready"}, 32'(req_ready32), 32'd1);
        issue_and_wait(vecs[i].op, lat);
        check_eq({tg, "_latency"}, 32'(lat), 32'(vecs[i].lat));
        check_eq({tg, "_valid16"}, 32'(resp_valid16), 32'd1);
        check_eq({tg, "_data32"}, resp_data32, vecs[i].r32);
        check_eq({tg, "_flags32"}, {29'd0, inexact32, overflow32, invalid32}, {29'd0, vecs[i].f32});
        check_eq({tg, "_data16"}, {16'd0, resp_data16}, {16'd0, vecs[i].r16});
        check_eq({tg, "_flags16"}, {29'd0, inexact16, overflow16, invalid16}, {29'd0, vecs[i].f16});
        // resp_ready is high, so the handshake completes on the next edge.
        @(posedge clk);
        #1;
        check_eq({tg, "_valid_drop"}, 32'(resp_valid32), 32'd0);
    endtask

    initial begin
        int lat;

        vecs[0]  = '{16'h3C00, 32'h0000_0001, 3'b000, 16'h0001, 3'b000, 13};
        vecs[1]  = '{16'h4000, 32'h0000_0002, 3'b000, 16'h0002, 3'b000, 12};
        vecs[2]  = '{16'h7BFF, 32'h0000_FFE0, 3'b000, 16'h7FFF, 3'b010,  8};
        vecs[3]  = '{16'hC100, 32'hFFFF_FFFE, 3'b100, 16'hFFFE, 3'b100, 12};
        vecs[4]  = '{16'h3800, 32'h0000_0000, 3'b100, 16'h0000, 3'b100,  3};
        vecs[5]  = '{16'h8000, 32'h0000_0000, 3'b000, 16'h0000, 3'b000,  3};
        vecs[6]  = '{16'h0001, 32'h0000_0000, 3'b100, 16'h0000, 3'b100,  3};
        vecs[7]  = '{16'h7E00, 32'h0000_0000, 3'b001, 16'h0000, 3'b001,  3};
        vecs[8]  = '{16'h7C00, 32'h7FFF_FFFF, 3'b010, 16'h7FFF, 3'b010,  3};
        vecs[9]  = '{16'hFC00, 32'h8000_0000, 3'b010, 16'h8000, 3'b010,  3};
        vecs[10] = '{16'hF800, 32'hFFFF_8000, 3'b000, 16'h8000, 3'b000,  8};
        vecs[11] = '{16'hF801, 32'hFFFF_7FE0, 3'b000, 16'h8000, 3'b010,  8};

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_data   = 16'h0000;
        resp_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_req_ready", 32'(req_ready32), 32'd1);
        check_eq("rst_resp_valid", 32'(resp_valid32), 32'd0);
        check_eq("rst_data", resp_data32, 32'd0);
        check_eq("rst_flags", {29'd0, inexact32, overflow32, invalid32}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(i);

        // Backpressure: result must stay put and a pending request must not be taken.
        resp_ready = 1'b0;
        issue_and_wait(16'h4000, lat);
        check_eq("bp_latency", 32'(lat), 32'd12);
        @(negedge clk);
        req_data  = 16'h3C00;
        req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check_eq($sformatf("bp_hold_valid_%0d", k), 32'(resp_valid32), 32'd1);
            check_eq($sformatf("bp_hold_data_%0d", k), resp_data32, 32'd2);
            check_eq($sformatf("bp_hold_flags_%0d", k), {29'd0, inexact32, overflow32, invalid32}, 32'd0);
            check_eq($sformatf("bp_hold_ready_%0d", k), 32'(req_ready32), 32'd0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("bp_hs_valid", 32'(resp_valid32), 32'd0);
        check_eq("bp_hs_ready", 32'(req_ready32), 32'd1);
        check_eq("bp_hs_data_kept", resp_data32, 32'd2);
        @(posedge clk);
        #1;
        check_eq("bp_accept", 32'(req_ready32), 32'd0);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid32 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq("bp_next_latency", 32'(lat), 32'd13);
        check_eq("bp_next_data", resp_data32, 32'd1);
        @(posedge clk);
        #1;

        // Reset mid-SHIFT, asynchronously (checked before any further edge).
        @(negedge clk);
        req_data  = 16'hFC00;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid32 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        @(posedge clk);
        #1;
        check_eq("pre_rst_data", resp_data32, 32'h8000_0000);
        @(negedge clk);
        req_data  = 16'h3C00;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_resp_valid", 32'(resp_valid32), 32'd0);
        check_eq("arst_req_ready", 32'(req_ready32), 32'd1);
        check_eq("arst_data32", resp_data32, 32'd0);
        check_eq("arst_data16", {16'd0, resp_data16}, 32'd0);
        check_eq("arst_flags", {29'd0, inexact32, overflow32, invalid32}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_vec(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
